cic_comb_sched: RTL and testbench

//  Time-multiplexed comb controller for the I/Q CIC decimators of the AM SDR. Each channel's

---
 rtl/cic_pkg.sv | 23 ++
 rtl/cic_delay_bank.sv | 37 +++
 rtl/cic_comb_sched.sv | 168 ++++++++++++++++
 tb/tb_cic_comb_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared types and defaults for the time-multiplexed CIC comb scheduler.
// Holds the FSM state encoding, channel IDs and default datapath sizes.
package cic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic CH_I = 1'b0;
  localparam logic CH_Q = 1'b1;

  localparam int DEF_WIDTH    = 20;
  localparam int DEF_STAGES   = 3;
  localparam int DEF_OUT_BITS = 16;

  // Stage-index width; a single-stage comb still needs a 1-bit index.
  function automatic int stg_bits(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/cic_delay_bank.sv
// Per-channel comb delay registers: 2 x STAGES words, one combinational read
// port and one write port sharing the {ch, stg} address, cleared on rst.
module cic_delay_bank
  import cic_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int SW     = stg_bits(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_i,
  input  logic [SW-1:0]    stg_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [2][STAGES];

  assign rd_data_o = mem_q[ch_i][stg_i];

  // NOTE: these are flops, not a RAM macro, so a full clear is legal; stale
  // delay contents would corrupt the first samples after a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int s = 0; s < STAGES; s++) begin
          mem_q[c][s] <= '0;
        end
      end
    end else if (we_i) begin
      mem_q[ch_i][stg_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cic_comb_sched.sv
// Shared-subtractor comb scheduler for the I/Q CIC decimators: captures one
// sample per channel, round-robins between I and Q, emits paired outputs.
module cic_comb_sched
  import cic_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STAGES   = DEF_STAGES,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_tick,
  input  logic [WIDTH-1:0]    i_sample,
  input  logic                q_tick,
  input  logic [WIDTH-1:0]    q_sample,
  output logic [OUT_BITS-1:0] i_out,
  output logic [OUT_BITS-1:0] q_out,
  output logic                out_tick,
  output logic                busy,
  output logic                overrun
);

  localparam int            SW       = stg_bits(STAGES);
  localparam logic [SW-1:0] LAST_STG = SW'(STAGES - 1);

  state_t              state_q, state_d;
  logic [1:0]          pend_q, pend_d;
  logic [1:0]          done_q, done_d;
  logic [WIDTH-1:0]    samp_i_q, samp_i_d;
  logic [WIDTH-1:0]    samp_q_q, samp_q_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic                ch_q, ch_d;
  logic                last_q, last_d;
  logic [SW-1:0]       stg_q, stg_d;
  logic [OUT_BITS-1:0] i_out_q, i_out_d;
  logic [OUT_BITS-1:0] q_out_q, q_out_d;
  logic                out_tick_q, out_tick_d;
  logic                overrun_q, overrun_d;

  logic                grant;
  logic                grant_ch;
  logic                dly_we;
  logic [WIDTH-1:0]    dly_rd;
  logic [WIDTH-1:0]    diff;
  logic [1:0]          ticks;
  logic [1:0]          consumed;

  cic_delay_bank #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .SW     (SW)
  ) u_dly (
    .clk       (CLK),
    .rst       (RST),
    .ch_i      (ch_q),
    .stg_i     (stg_q),
    .we_i      (dly_we),
    .wr_data_i (opnd_q),
    .rd_data_o (dly_rd)
  );

  // Modulo-2^WIDTH difference; wrap-around is what makes the CIC exact.
  assign diff = opnd_q - dly_rd;

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    last_d     = last_q;
    stg_d      = stg_q;
    opnd_d     = opnd_q;
    done_d     = done_q;
    i_out_d    = i_out_q;
    q_out_d    = q_out_q;
    out_tick_d = 1'b0;
    grant      = 1'b0;
    grant_ch   = ch_q;
    dly_we     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          grant    = 1'b1;
          grant_ch = (pend_q == 2'b11) ? ~last_q : pend_q[CH_Q];
          ch_d     = grant_ch;
          last_d   = grant_ch;
          opnd_d   = (grant_ch == CH_Q) ? samp_q_q : samp_i_q;
          stg_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        dly_we = 1'b1;
        opnd_d = diff;
        if (stg_q == LAST_STG) begin
          stg_d   = '0;
          state_d = ST_DONE;
        end else begin
          stg_d = stg_q + SW'(1);
        end
      end
      ST_DONE: begin
        if (ch_q == CH_Q) q_out_d = opnd_q[WIDTH-1 -: OUT_BITS];
        else              i_out_d = opnd_q[WIDTH-1 -: OUT_BITS];
        if (done_q[~ch_q]) begin
          out_tick_d = 1'b1;
          done_d     = 2'b00;
        end else begin
          done_d[ch_q] = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A tick in the grant cycle of its own channel is a fresh sample, not an overrun.
  always_comb begin
    ticks     = {q_tick, i_tick};
    consumed  = {grant & (grant_ch == CH_Q), grant & (grant_ch == CH_I)};
    pend_d    = (pend_q & ~consumed) | ticks;
    samp_i_d  = i_tick ? i_sample : samp_i_q;
    samp_q_d  = q_tick ? q_sample : samp_q_q;
    overrun_d = overrun_q | (|(ticks & pend_q & ~consumed));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      done_q     <= '0;
      samp_i_q   <= '0;
      samp_q_q   <= '0;
      opnd_q     <= '0;
      ch_q       <= CH_I;
      last_q     <= CH_Q;
      stg_q      <= '0;
      i_out_q    <= '0;
      q_out_q    <= '0;
      out_tick_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      samp_i_q   <= samp_i_d;
      samp_q_q   <= samp_q_d;
      opnd_q     <= opnd_d;
      ch_q       <= ch_d;
      last_q     <= last_d;
      stg_q      <= stg_d;
      i_out_q    <= i_out_d;
      q_out_q    <= q_out_d;
      out_tick_q <= out_tick_d;
      overrun_q  <= overrun_d;
    end
  end

  assign i_out    = i_out_q;
  assign q_out    = q_out_q;
  assign out_tick = out_tick_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != ST_IDLE) | grant;

endmodule

// File: tb/tb_cic_comb_sched.sv
// Directed bench for cic_comb_sched (WIDTH=20, STAGES=3, OUT_BITS=16):
// table-driven impulse pairs plus hand sequences for latency, overrun and reset.
module tb_cic_comb_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        i_tick = 1'b0;
  logic [19:0] i_sample = '0;
  logic        q_tick = 1'b0;
  logic [19:0] q_sample = '0;
  logic [15:0] i_out;
  logic [15:0] q_out;
  logic        out_tick;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [19:0] is;
    logic [19:0] qs;
    logic [15:0] ei;
    logic [15:0] eq;
  } vec_t;

  vec_t imp[5];

  cic_comb_sched #(
    .WIDTH    (20),
    .STAGES   (3),
    .OUT_BITS (16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .i_tick   (i_tick),
    .i_sample (i_sample),
    .q_tick   (q_tick),
    .q_sample (q_sample),
    .i_out    (i_out),
    .q_out    (q_out),
    .out_tick (out_tick),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic tick_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) tick_edge();
    RST = 1'b0;
  endtask

  // Drive one simultaneous I/Q pair at cycle 0 and wait for out_tick.
  task automatic send_pair(input logic [19:0] is, input logic [19:0] qs, output int lat);
    lat      = -1;
    i_sample = is;
    q_sample = qs;
    i_tick   = 1'b1;
    q_tick   = 1'b1;
    tick_edge();
    i_tick = 1'b0;
    q_tick = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (out_tick) begin
        lat = c;
        break;
      end
      tick_edge();
    end
    tick_edge();
  endtask

  task automatic run_impulse(input string tag);
    int lat;
    for (int k = 0; k < 5; k++) begin
      send_pair(imp[k].is, imp[k].qs, lat);
      check($sformatf("%s_lat_%0d", tag, k), lat, 11);
      check($sformatf("%s_i_%0d", tag, k), i_out, imp[k].ei);
      check($sformatf("%s_q_%0d", tag, k), q_out, imp[k].eq);
    end
  endtask

  // Simultaneous ticks at c0 (I=80 -> 5, Q=32 -> 2 from clean delays);
  // optionally assert RST during c3.
  task automatic run_latency(input bit mid_rst);
    int n_ot;
    int ot_cyc;
    n_ot     = 0;
    ot_cyc   = -1;
    i_sample = 20'd80;
    q_sample = 20'd32;
    i_tick   = 1'b1;
    q_tick   = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick_edge();
      if (c == 1) begin
        i_tick = 1'b0;
        q_tick = 1'b0;
      end
      if (mid_rst && c == 3) RST = 1'b1;
      if (mid_rst && c == 4) RST = 1'b0;
      @(negedge CLK);
      if (out_tick) begin
        n_ot++;
        ot_cyc = c;
      end
      if (!mid_rst) begin
        case (c)
          1:  check("lat_busy_grant_c1", busy, 1);
          5:  check("lat_i_old_c5", i_out, 0);
          6:  begin
                check("lat_i_new_c6", i_out, 5);
                check("lat_busy_qgrant_c6", busy, 1);
              end
          10: check("lat_q_old_c10", q_out, 0);
          11: check("lat_q_new_c11", q_out, 2);
          12: check("lat_busy_idle_c12", busy, 0);
          default: ;
        endcase
      end else begin
        if (c == 3) check("mrst_busy_c3", busy, 1);
        if (c == 4) begin
          check("mrst_i_out", i_out, 0);
          check("mrst_q_out", q_out, 0);
          check("mrst_busy", busy, 0);
          check("mrst_overrun", overrun, 0);
        end
      end
    end
    if (!mid_rst) begin
      check("lat_out_tick_count", n_ot, 1);
      check("lat_out_tick_cycle", ot_cyc, 11);
    end else begin
      check("mrst_out_tick_count", n_ot, 0);
    end
    tick_edge();
  endtask

  initial begin
    int lat;
    int n_ot;

    // Impulse of height 16 through three comb stages: 16,-48,48,-16,0 -> /16.
    imp[0] = '{20'd16, 20'd0, 16'h0001, 16'h0000};
    imp[1] = '{20'd0,  20'd0, 16'hFFFD, 16'h0000};
    imp[2] = '{20'd0,  20'd0, 16'h0003, 16'h0000};
    imp[3] = '{20'd0,  20'd0, 16'hFFFF, 16'h0000};
    imp[4] = '{20'd0,  20'd0, 16'h0000, 16'h0000};

    // Reset state
    do_reset();
    @(negedge CLK);
    check("rst_i_out", i_out, 0);
    check("rst_q_out", q_out, 0);
    check("rst_out_tick", out_tick, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    tick_edge();

    run_impulse("imp");
    check("imp_overrun", overrun, 0);

    // Latency of a simultaneous pair
    do_reset();
    run_latency(1'b0);

    // Q alone never pairs; a later I completes the pair exactly once
    do_reset();
    q_sample = 20'd48;
    q_tick   = 1'b1;
    n_ot     = 0;
    for (int c = 1; c <= 20; c++) begin
      tick_edge();
      q_tick = 1'b0;
      @(negedge CLK);
      if (out_tick) n_ot++;
    end
    check("qonly_q_out", q_out, 3);
    check("qonly_i_out", i_out, 0);
    check("qonly_no_tick", n_ot, 0);
    tick_edge();
    i_sample = 20'd16;
    i_tick   = 1'b1;
    n_ot     = 0;
    for (int c = 1; c <= 20; c++) begin
      tick_edge();
      i_tick = 1'b0;
      @(negedge CLK);
      if (out_tick) n_ot++;
    end
    check("qonly_then_i_ticks", n_ot, 1);
    check("qonly_then_i_out", i_out, 1);
    check("qonly_then_q_out", q_out, 3);
    tick_edge();

    // Overrun: I ticks at c0 (16), c3 (32), c5 (80); 80 replaces 32
    do_reset();
    i_sample = 20'd16;
    i_tick   = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick_edge();
      i_tick = 1'b0;
      if (c == 3) begin
        i_sample = 20'd32;
        i_tick   = 1'b1;
      end
      if (c == 5) begin
        i_sample = 20'd80;
        i_tick   = 1'b1;
      end
      @(negedge CLK);
      if (c == 5) check("ovr_clear_c5", overrun, 0);
      if (c == 6) begin
        check("ovr_set_c6", overrun, 1);
        check("ovr_first_i_c6", i_out, 1);
      end
    end
    check("ovr_second_i", i_out, 2);
    check("ovr_sticky", overrun, 1);
    check("ovr_busy_idle", busy, 0);
    tick_edge();

    // Tick during the grant cycle is a fresh sample, not an overrun
    do_reset();
    i_sample = 20'd16;
    i_tick   = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick_edge();
      if (c >= 2) i_tick = 1'b0;
      @(negedge CLK);
    end
    check("grant_tick_overrun", overrun, 0);
    check("grant_tick_i_out", i_out, 16'hFFFE);
    tick_edge();

    // Modulo wrap across the sign boundary
    do_reset();
    send_pair(20'h7FFF0, 20'h0, lat);
    check("wrap_lat0", lat, 11);
    check("wrap_i0", i_out, 16'h7FFF);
    send_pair(20'h80010, 20'h0, lat);
    check("wrap_lat1", lat, 11);
    check("wrap_i1", i_out, 16'h0004);
    check("wrap_q1", q_out, 0);
    check("wrap_overrun", overrun, 0);

    // Reset mid-operation, then the impulse must replay identically
    run_latency(1'b1);
    run_impulse("replay");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
